sw_host_driver: RTL and testbench
=================================

Name: sw_host_driver

Overview:
- Host-side job controller that drives the user/data interface of the SmithWaterman accelerator top.
- On a load command it sends a T sequence from a host T-buffer over the 18-bit T bus.
- On a run command it starts the calculation, answers every S-chunk request from a host S-buffer, and captures the score.
- Sits between the host register/memory fabric and the accelerator top.

Parameters:
PE_SIZE, 64, bases per S chunk (matches accelerator PE array size)
PE_SIZE_LOG, 6, log2(PE_SIZE)
ADDR_W, 10, word-address width of T and S buffers
RES_W, 16, score width (matches accelerator V/E/F width)
T_LEAD, 3, cycles the length word is held on o_t, counted from the set_t cycle
BUSY_WAIT, 16, max cycles from command to accelerator busy-high
TIMEOUT, 2^20, max cycles in RUN before error

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_cmd_load_t  in  1  pulse: load T of length i_t_len
i_cmd_run  in  1  pulse: align S of length i_s_len against loaded T
i_t_len  in  18  T length in bases, sampled with command
i_s_len  in  ADDR_W+PE_SIZE_LOG  S length in bases, sampled with command
o_ready  out  1  idle, commands accepted
o_result  out  RES_W  captured score
o_result_valid  out  1  one-cycle pulse with o_result
o_error  out  1  one-cycle pulse on protocol error or timeout
o_t_raddr  out  ADDR_W  T-buffer read address (1-cycle synchronous read)
i_t_rdata  in  18  T-buffer word, 9 bases, base 0 in bits[1:0]
o_s_raddr  out  ADDR_W  S-buffer read address (1-cycle synchronous read)
i_s_rdata  in  PE_SIZE*2  S-buffer word, base 0 in bits[1:0]
o_set_t  out  1  to accelerator i_set_t
o_start_cal  out  1  to accelerator i_start_cal
o_t  out  18  to accelerator i_t
i_request_s  in  1  from accelerator o_request_s
o_s  out  PE_SIZE*2  to accelerator i_s
o_s_valid  out  PE_SIZE_LOG+1  to accelerator i_s_valid, count of valid bases
i_sw_busy  in  1  accelerator o_busy
i_sw_result  in  RES_W  accelerator o_result
i_sw_valid  in  1  accelerator o_valid

Behaviour:
- Reset: all outputs 0 except o_ready=1. State=IDLE, t_loaded=0. Reset mid-job abandons it silently.
- FSM states: IDLE, T_SEND, T_WAIT, C_ARM, C_RUN, C_DRAIN, ERR.
- IDLE:
  - i_cmd_load_t -> T_SEND. Load has priority if both commands arrive in the same cycle; the run is dropped.
  - i_cmd_run with t_loaded=1 and i_t_len of the last load !=0 -> C_ARM.
  - i_cmd_run with t_loaded=0 -> o_error pulse, stay IDLE.
  - Commands outside IDLE are ignored.
  - o_ready=1 only in IDLE.
- T_SEND timing:
  - Cycle 0: o_set_t=1 for exactly one cycle.
  - Cycles 0..T_LEAD-1: o_t = i_t_len.
  - From cycle T_LEAD: one word per cycle, o_t = T word k, for k = 0..ceil(len/9)-1.
  - T-buffer reads are issued one cycle early so there are no bubbles.
  - Unused bases in the last word are driven 0.
  - After the last word: o_t=0, go to T_WAIT.
- T_WAIT:
  - Requires i_sw_busy high within BUSY_WAIT cycles of the set_t cycle; otherwise ERR.
  - Once busy has been seen high, busy low -> t_loaded=1, IDLE.
  - i_t_len=0 is legal: length word only, t_loaded stays 0.
- C_ARM: o_start_cal=1 for one cycle. S chunk counter and remaining-base counter are cleared and loaded. Go to C_RUN.
- C_RUN:
  - i_sw_busy not seen high within BUSY_WAIT cycles -> ERR.
  - Each i_request_s pulse at cycle n:
    - o_s_raddr = chunk index at cycle n.
    - At cycle n+1, o_s = i_s_rdata with bases beyond remaining masked to 0, and o_s_valid = min(remaining, PE_SIZE).
    - Both are registered/held until the next request.
    - remaining decrements; chunk index increments.
  - Request after remaining=0 -> o_s_valid=0, o_s=0. This is the end marker used when S length is a multiple of PE_SIZE.
  - Request in back-to-back cycles is served every cycle.
  - i_sw_valid -> capture i_sw_result. o_result_valid=1 next cycle; o_result held until the next capture. Go to C_DRAIN.
  - TIMEOUT reached without i_sw_valid -> ERR.
- C_DRAIN: i_sw_busy low -> IDLE. A request arriving here is still served (end marker).
- ERR: o_error=1 for one cycle, then IDLE. t_loaded is cleared if the error came from the T path.
- A request and valid in the same cycle: the request is served, then valid is handled.

Test Plan:
- Load t_len=20 (words 0x0_1B6E4, 0x2A5F1, 0x00003): o_set_t pulse; o_t=20 for 3 cycles, then the 3 words; 3rd word bases 2..8 are 0. Model busy high 2 cycles later, low 10 cycles later -> o_ready after drop.
- Run s_len=150, PE_SIZE=64: 3 requests -> o_s_valid 64, 64, 22 (22-base mask verified). Model valid with result 0x0042 -> o_result_valid pulse, o_result=0x0042.
- Run s_len=128: 3rd request -> o_s_valid=0, o_s=0. Back-to-back requests both served one cycle after each.
- Run before any load -> o_error pulse, no o_start_cal. Load and run in the same cycle -> only o_set_t asserted.
- Busy never rises after set_t -> o_error at cycle BUSY_WAIT. Busy stuck in RUN -> o_error at TIMEOUT (bench TIMEOUT=200).
- rst_n low during C_RUN -> all outputs 0, o_ready=1 asynchronously; a new load works after release.

Source files
------------

// File: rtl/sw_host_driver.sv
// sw_host_driver: host-side job controller for the SmithWaterman accelerator top.
//   Load command : streams a T sequence (length word, then 9-base words) from a
//                  host T-buffer onto the 18-bit T bus.
//   Run command  : starts the calculation, serves every S-chunk request from a
//                  host S-buffer and captures the final score.
// Ports:
//   clk / rst_n                    clock, async active-low reset
//   i_cmd_load_t / i_cmd_run       command pulses (accepted only when o_ready)
//   i_t_len / i_s_len              job lengths in bases, sampled with command
//   o_ready                        idle
//   o_result / o_result_valid      captured score + one-cycle strobe
//   o_error                        one-cycle pulse on protocol error / timeout
//   o_t_raddr / i_t_rdata          T-buffer port (1-cycle synchronous read)
//   o_s_raddr / i_s_rdata          S-buffer port (1-cycle synchronous read)
//   o_set_t, o_start_cal, o_t,
//   i_request_s, o_s, o_s_valid,
//   i_sw_busy, i_sw_result,
//   i_sw_valid                     accelerator user/data interface
module sw_host_driver #(
  parameter int PE_SIZE     = 64,
  parameter int PE_SIZE_LOG = 6,
  parameter int ADDR_W      = 10,
  parameter int RES_W       = 16,
  parameter int T_LEAD      = 3,
  parameter int BUSY_WAIT   = 16,
  parameter int TIMEOUT     = 2**20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_cmd_load_t,
  input  logic                          i_cmd_run,
  input  logic [17:0]                   i_t_len,
  input  logic [ADDR_W+PE_SIZE_LOG-1:0] i_s_len,
  output logic                          o_ready,
  output logic [RES_W-1:0]              o_result,
  output logic                          o_result_valid,
  output logic                          o_error,
  output logic [ADDR_W-1:0]             o_t_raddr,
  input  logic [17:0]                   i_t_rdata,
  output logic [ADDR_W-1:0]             o_s_raddr,
  input  logic [PE_SIZE*2-1:0]          i_s_rdata,
  output logic                          o_set_t,
  output logic                          o_start_cal,
  output logic [17:0]                   o_t,
  input  logic                          i_request_s,
  output logic [PE_SIZE*2-1:0]          o_s,
  output logic [PE_SIZE_LOG:0]          o_s_valid,
  input  logic                          i_sw_busy,
  input  logic [RES_W-1:0]              i_sw_result,
  input  logic                          i_sw_valid
);

  localparam int SL_W    = ADDR_W + PE_SIZE_LOG;
  localparam int SV_W    = PE_SIZE_LOG + 1;
  localparam int SW      = PE_SIZE * 2;
  localparam int CYC_MAX = (TIMEOUT > BUSY_WAIT) ? ((TIMEOUT > T_LEAD) ? TIMEOUT : T_LEAD)
                                                 : ((BUSY_WAIT > T_LEAD) ? BUSY_WAIT : T_LEAD);
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CYC_W-1:0] LEAD    = CYC_W'(T_LEAD);
  localparam logic [CYC_W-1:0] LEAD_M1 = CYC_W'(T_LEAD - 1);
  localparam logic [CYC_W-1:0] BW_LAST = CYC_W'(BUSY_WAIT - 1);
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT - 1);
  localparam logic [SV_W-1:0]  PE_SV   = SV_W'(PE_SIZE);

  typedef enum logic [2:0] {IDLE, T_SEND, T_WAIT, C_ARM, C_RUN, C_DRAIN, ERR} state_t;

  state_t state, state_nxt;

  logic              t_loaded;
  logic [17:0]       t_len_q, t_rem;
  logic [ADDR_W-1:0] t_word;
  logic [CYC_W-1:0]  cyc;        // cycles since command; 0 = set_t / start_cal cycle
  logic              busy_seen;
  logic              idle_err;
  logic [SL_W-1:0]   s_len_q, s_rem;
  logic [ADDR_W-1:0] s_chunk;
  logic [SV_W-1:0]   sv_q;
  logic              req_d;
  logic [SW-1:0]     s_hold;
  logic [RES_W-1:0]  res_q;
  logic              rv_q;

  logic              dphase, t_last, busy_to, run_to, serve;
  logic [SV_W-1:0]   s_take;
  logic [17:0]       t_masked;
  logic [SW-1:0]     s_masked;

  assign dphase  = cyc >= LEAD;
  // Last T word is on the bus this cycle; a zero-length T ends right after the lead.
  assign t_last  = (dphase && t_rem <= 18'd9) || (cyc == LEAD_M1 && t_rem == '0);
  assign busy_to = !busy_seen && !i_sw_busy && cyc == BW_LAST;
  assign run_to  = !i_sw_valid && cyc == TO_LAST;
  assign serve   = i_request_s && (state == C_RUN || state == C_DRAIN);
  assign s_take  = (s_rem >= SL_W'(PE_SIZE)) ? PE_SV : s_rem[SV_W-1:0];

  // Zero the bases past the remaining length in the word currently returned.
  for (genvar b = 0; b < 9; b++) begin : g_tmask
    assign t_masked[2*b +: 2] = (18'(b) < t_rem) ? i_t_rdata[2*b +: 2] : 2'b00;
  end
  for (genvar b = 0; b < PE_SIZE; b++) begin : g_smask
    assign s_masked[2*b +: 2] = (SV_W'(b) < sv_q) ? i_s_rdata[2*b +: 2] : 2'b00;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_cmd_load_t)               state_nxt = T_SEND;
               else if (i_cmd_run && t_loaded) state_nxt = C_ARM;
      T_SEND:  if (busy_to)                    state_nxt = ERR;
               else if (t_last)                state_nxt = T_WAIT;
      T_WAIT:  if (busy_to)                    state_nxt = ERR;
               else if (busy_seen && !i_sw_busy) state_nxt = IDLE;
      C_ARM:                                   state_nxt = C_RUN;
      C_RUN:   if (i_sw_valid)                 state_nxt = C_DRAIN;
               else if (busy_to || run_to)     state_nxt = ERR;
      C_DRAIN: if (!i_sw_busy)                 state_nxt = IDLE;
      ERR:                                     state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_loaded  <= 1'b0;
      t_len_q   <= '0;
      t_rem     <= '0;
      t_word    <= '0;
      cyc       <= '0;
      busy_seen <= 1'b0;
      idle_err  <= 1'b0;
      s_len_q   <= '0;
      s_rem     <= '0;
      s_chunk   <= '0;
      sv_q      <= '0;
      req_d     <= 1'b0;
      s_hold    <= '0;
      res_q     <= '0;
      rv_q      <= 1'b0;
    end else begin
      if (state == IDLE)        cyc <= '0;
      else if (cyc != '1)       cyc <= cyc + CYC_W'(1);

      if (state == IDLE)        busy_seen <= 1'b0;
      else if (i_sw_busy)       busy_seen <= 1'b1;

      idle_err <= (state == IDLE) && i_cmd_run && !i_cmd_load_t && !t_loaded;

      // A new load invalidates the previous T, so any T-path error leaves t_loaded clear.
      if (state == IDLE && i_cmd_load_t) begin
        t_loaded <= 1'b0;
        t_len_q  <= i_t_len;
        t_rem    <= i_t_len;
        t_word   <= '0;
      end else if (state == IDLE && i_cmd_run && t_loaded) begin
        s_len_q  <= i_s_len;
      end

      // Reads run one cycle ahead of the data phase so words stream without bubbles.
      if (state == T_SEND && cyc >= LEAD_M1) t_word <= t_word + ADDR_W'(1);
      if (state == T_SEND && dphase)         t_rem  <= (t_rem > 18'd9) ? t_rem - 18'd9 : '0;

      if (state == T_WAIT && state_nxt == IDLE) t_loaded <= (t_len_q != '0);

      if (state == C_ARM) begin
        s_rem   <= s_len_q;
        s_chunk <= '0;
        sv_q    <= '0;
        s_hold  <= '0;
        req_d   <= 1'b0;
      end else begin
        req_d <= serve;
        if (serve) begin
          sv_q    <= s_take;
          s_rem   <= s_rem - SL_W'(s_take);
          s_chunk <= s_chunk + ADDR_W'(1);
        end
        if (req_d) s_hold <= s_masked;
      end

      rv_q <= (state == C_RUN) && i_sw_valid;
      if (state == C_RUN && i_sw_valid) res_q <= i_sw_result;
    end
  end

  // Outputs
  always_comb begin
    o_ready        = (state == IDLE);
    o_set_t        = (state == T_SEND) && (cyc == '0);
    o_start_cal    = (state == C_ARM);
    o_t            = '0;
    if (state == T_SEND) o_t = dphase ? t_masked : t_len_q;
    o_t_raddr      = t_word;
    o_s_raddr      = s_chunk;
    // Fresh chunk is passed straight through on the return cycle, then held.
    o_s            = req_d ? s_masked : s_hold;
    o_s_valid      = sv_q;
    o_error        = (state == ERR) || idle_err;
    o_result       = res_q;
    o_result_valid = rv_q;
  end

endmodule

// File: tb/tb_sw_host_driver.sv
// Directed self-checking bench for sw_host_driver (TIMEOUT shortened to 200).
module tb_sw_host_driver;

  localparam int PE_SIZE = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cmd_load_t, i_cmd_run;
  logic [17:0]   i_t_len;
  logic [15:0]   i_s_len;
  logic          o_ready;
  logic [15:0]   o_result;
  logic          o_result_valid, o_error;
  logic [9:0]    o_t_raddr, o_s_raddr;
  logic [17:0]   i_t_rdata;
  logic [127:0]  i_s_rdata;
  logic          o_set_t, o_start_cal;
  logic [17:0]   o_t;
  logic          i_request_s;
  logic [127:0]  o_s;
  logic [6:0]    o_s_valid;
  logic          i_sw_busy;
  logic [15:0]   i_sw_result;
  logic          i_sw_valid;

  logic [17:0]   tmem [0:3];
  logic [127:0]  smem [0:3];

  int nchk = 0;
  int nerr = 0;

  sw_host_driver #(.TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_load_t(i_cmd_load_t), .i_cmd_run(i_cmd_run),
    .i_t_len(i_t_len), .i_s_len(i_s_len),
    .o_ready(o_ready), .o_result(o_result), .o_result_valid(o_result_valid),
    .o_error(o_error),
    .o_t_raddr(o_t_raddr), .i_t_rdata(i_t_rdata),
    .o_s_raddr(o_s_raddr), .i_s_rdata(i_s_rdata),
    .o_set_t(o_set_t), .o_start_cal(o_start_cal), .o_t(o_t),
    .i_request_s(i_request_s), .o_s(o_s), .o_s_valid(o_s_valid),
    .i_sw_busy(i_sw_busy), .i_sw_result(i_sw_result), .i_sw_valid(i_sw_valid)
  );

  always #5 clk = ~clk;

  // Host buffers with 1-cycle synchronous read
  always @(posedge clk) begin
    i_t_rdata <= tmem[o_t_raddr[1:0]];
    i_s_rdata <= smem[o_s_raddr[1:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_cmd_load_t = 0; i_cmd_run = 0; i_t_len = '0; i_s_len = '0;
    i_request_s = 0; i_sw_busy = 0; i_sw_result = '0; i_sw_valid = 0;
    tmem[0] = 18'h1B6E4; tmem[1] = 18'h2A5F1; tmem[2] = 18'h2AB03; tmem[3] = 18'h3FFFF;
    smem[0] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    smem[1] = {4{32'h5A5AC3C3}};
    smem[2] = {4{32'hDEADBEEF}};
    smem[3] = {4{32'hFFFFFFFF}};

    // Reset state
    #12;
    chk("rst_ready", o_ready, 1);
    chk("rst_set_t", o_set_t, 0);
    chk("rst_start", o_start_cal, 0);
    chk("rst_t", o_t, 0);
    chk("rst_s", o_s, 0);
    chk("rst_s_valid", o_s_valid, 0);
    chk("rst_error", o_error, 0);
    chk("rst_rv", o_result_valid, 0);
    chk("rst_result", o_result, 0);
    tick; rst_n = 1'b1; tick;

    // Run before any load
    i_cmd_run = 1; i_s_len = 150; tick; i_cmd_run = 0;
    chk("noload_err", o_error, 1);
    chk("noload_start", o_start_cal, 0);
    chk("noload_ready", o_ready, 1);
    tick;
    chk("noload_err_clr", o_error, 0);
    chk("noload_start2", o_start_cal, 0);

    // Load t_len=20 together with a run: load wins
    i_cmd_load_t = 1; i_cmd_run = 1; i_t_len = 20; tick;
    i_cmd_load_t = 0; i_cmd_run = 0;
    chk("ld_set_t0", o_set_t, 1);
    chk("ld_start0", o_start_cal, 0);
    chk("ld_t0", o_t, 20);
    chk("ld_ready0", o_ready, 0);
    tick;
    chk("ld_set_t1", o_set_t, 0);
    chk("ld_t1", o_t, 20);
    tick;
    chk("ld_t2", o_t, 20);
    chk("ld_start2", o_start_cal, 0);
    i_sw_busy = 1;
    tick; chk("ld_w0", o_t, 18'h1B6E4);
    tick; chk("ld_w1", o_t, 18'h2A5F1);
    tick; chk("ld_w2_mask", o_t, 18'h00003);
    tick; chk("ld_t_after", o_t, 0);
    chk("ld_err", o_error, 0);
    repeat (6) tick;
    i_sw_busy = 0;
    chk("ld_busy_ready", o_ready, 0);
    tick;
    chk("ld_done_ready", o_ready, 1);
    chk("ld_done_err", o_error, 0);

    // Run s_len=150: chunks of 64, 64, 22
    i_cmd_run = 1; i_s_len = 150; tick; i_cmd_run = 0;
    chk("r150_start", o_start_cal, 1);
    chk("r150_ready", o_ready, 0);
    i_sw_busy = 1; tick;
    chk("r150_start_clr", o_start_cal, 0);
    chk("r150_raddr0", o_s_raddr, 0);
    i_request_s = 1; tick; i_request_s = 0;
    chk("r150_v0", o_s_valid, 64);
    chk("r150_s0", o_s, 128'h0123456789ABCDEF_FEDCBA9876543210);
    tick;
    chk("r150_s0_hold", o_s, 128'h0123456789ABCDEF_FEDCBA9876543210);
    chk("r150_raddr1", o_s_raddr, 1);
    i_request_s = 1; tick; i_request_s = 0;
    chk("r150_v1", o_s_valid, 64);
    chk("r150_s1", o_s, {4{32'h5A5AC3C3}});
    i_request_s = 1; tick; i_request_s = 0;
    chk("r150_v2", o_s_valid, 22);
    chk("r150_s2_mask", o_s, 128'hEEF_DEAD_BEEF);
    tick;
    chk("r150_s2_hold", o_s, 128'hEEF_DEAD_BEEF);
    chk("r150_v2_hold", o_s_valid, 22);
    i_sw_valid = 1; i_sw_result = 16'h0042; tick; i_sw_valid = 0;
    chk("r150_rv", o_result_valid, 1);
    chk("r150_res", o_result, 16'h0042);
    tick;
    chk("r150_rv_clr", o_result_valid, 0);
    chk("r150_res_hold", o_result, 16'h0042);
    chk("r150_drain", o_ready, 0);
    i_sw_busy = 0; tick;
    chk("r150_idle", o_ready, 1);

    // Run s_len=128: back-to-back requests, then end marker
    i_cmd_run = 1; i_s_len = 128; tick; i_cmd_run = 0;
    chk("r128_start", o_start_cal, 1);
    i_sw_busy = 1; tick;
    i_request_s = 1; tick;
    chk("r128_v0", o_s_valid, 64);
    chk("r128_s0", o_s, 128'h0123456789ABCDEF_FEDCBA9876543210);
    tick; i_request_s = 0;
    chk("r128_v1", o_s_valid, 64);
    chk("r128_s1", o_s, {4{32'h5A5AC3C3}});
    i_request_s = 1; tick; i_request_s = 0;
    chk("r128_end_v", o_s_valid, 0);
    chk("r128_end_s", o_s, 0);
    i_sw_valid = 1; i_sw_result = 16'h1234; tick; i_sw_valid = 0;
    chk("r128_rv", o_result_valid, 1);
    chk("r128_res", o_result, 16'h1234);
    i_sw_busy = 0; tick;
    chk("r128_idle", o_ready, 1);

    // Busy never rises after set_t: error at cycle BUSY_WAIT (16)
    i_cmd_load_t = 1; i_t_len = 9; tick; i_cmd_load_t = 0;
    chk("bw_set_t", o_set_t, 1);
    repeat (15) tick;
    chk("bw_err15", o_error, 0);
    tick;
    chk("bw_err16", o_error, 1);
    tick;
    chk("bw_ready", o_ready, 1);
    chk("bw_err_clr", o_error, 0);
    // T-path error leaves no T loaded
    i_cmd_run = 1; i_s_len = 64; tick; i_cmd_run = 0;
    chk("bw_noload_err", o_error, 1);
    chk("bw_noload_start", o_start_cal, 0);
    tick;

    // Reload, then busy stuck in RUN: error at TIMEOUT (200)
    i_cmd_load_t = 1; i_t_len = 20; tick; i_cmd_load_t = 0;
    i_sw_busy = 1;
    repeat (8) tick;
    i_sw_busy = 0;
    repeat (2) tick;
    chk("rl_ready", o_ready, 1);
    i_cmd_run = 1; i_s_len = 64; tick; i_cmd_run = 0;
    chk("to_start", o_start_cal, 1);
    i_sw_busy = 1;
    repeat (199) tick;
    chk("to_err199", o_error, 0);
    tick;
    chk("to_err200", o_error, 1);
    tick;
    chk("to_ready", o_ready, 1);
    chk("to_err_clr", o_error, 0);
    i_sw_busy = 0;

    // Run error keeps T loaded; async reset mid-run
    i_cmd_run = 1; i_s_len = 150; tick; i_cmd_run = 0;
    chk("rr_start", o_start_cal, 1);
    i_sw_busy = 1; tick;
    i_request_s = 1; tick; i_request_s = 0;
    chk("rr_v0", o_s_valid, 64);
    #2; rst_n = 1'b0; #1;
    chk("arst_ready", o_ready, 1);
    chk("arst_s_valid", o_s_valid, 0);
    chk("arst_s", o_s, 0);
    chk("arst_start", o_start_cal, 0);
    chk("arst_result", o_result, 0);
    i_sw_busy = 0;
    tick; rst_n = 1'b1; tick;
    i_cmd_load_t = 1; i_t_len = 20; tick; i_cmd_load_t = 0;
    chk("post_set_t", o_set_t, 1);
    chk("post_t0", o_t, 20);
    i_sw_busy = 1;
    repeat (3) tick;
    chk("post_w0", o_t, 18'h1B6E4);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
